// File: rtl/wb_sched_pkg.sv
// rtl/wb_sched_pkg.sv - shared types, widths and helpers for the wishbone bus scheduler
package wb_sched_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    GRANT = 2'd1,
    ABORT = 2'd2
  } state_t;

  localparam int STAT_CNTw = 16;

  // Ceiling log2, never below 1 so it can size a vector directly.
  function automatic int log2(input int value);
    int r;
    r = 0;
    for (int i = 0; i < 31; i++) begin
      if ((1 << i) < value) r = i + 1;
    end
    return (r < 1) ? 1 : r;
  endfunction

endpackage

// File: rtl/one_hot_to_bin.sv
// rtl/one_hot_to_bin.sv - one-hot (or zero) vector to binary index
module one_hot_to_bin #(
  parameter int N = 4,
  parameter int W = 2
) (
  input  logic [N-1:0] onehot,
  output logic [W-1:0] bin
);

  always_comb begin
    bin = '0;
    for (int i = 0; i < N; i++) begin
      if (onehot[i]) bin = bin | W'(i);
    end
  end

endmodule

// File: rtl/wb_sched_rr_pick.sv
// rtl/wb_sched_rr_pick.sv - round-robin pick: rotate to pointer, take lowest request, rotate back
module rr_pick #(
  parameter int N = 4,
  parameter int W = 2
) (
  input  logic [N-1:0] req,
  input  logic [W-1:0] ptr,
  output logic [N-1:0] winner,
  output logic         valid
);

  logic [2*N-1:0] dbl_req;
  logic [2*N-1:0] dbl_win;
  logic [N-1:0]   rot;
  logic [N-1:0]   pick;

  always_comb begin
    dbl_req = {req, req} >> ptr;
    rot     = dbl_req[N-1:0];
    pick    = rot & (~rot + N'(1));
    dbl_win = {pick, pick} << ptr;
    winner  = dbl_win[2*N-1:N];
    valid   = |req;
  end

endmodule

// File: rtl/wb_bus_scheduler.sv
// rtl/wb_bus_scheduler.sv - round-robin wishbone grant with hung-transfer watchdog
// Optional per-master grant / abort statistics when WB_SCHED_STATS_EN is defined.
module wb_bus_scheduler
  import wb_sched_pkg::*;
#(
  parameter int M       = 4,
  parameter int TIMEOUT = 1024,
  localparam int TOw    = log2(TIMEOUT + 1),
  localparam int Mw     = (M > 1) ? log2(M) : 1
) (
  input  logic          clk,
  input  logic          reset,
  input  logic [M-1:0]  m_cyc_i_all,
  input  logic [M-1:0]  m_stb_i_all,
  input  logic          any_s_ack_i,
  input  logic          any_s_err_i,
  input  logic          any_s_rty_i,
  output logic [M-1:0]  m_grant_onehot_o,
  output logic [Mw-1:0] m_grant_bin_o,
  output logic [M-1:0]  m_timeout_err_o,
  output logic          bus_busy_o,
  output logic          timeout_evt_o
`ifdef WB_SCHED_STATS_EN
  ,
  output logic [STAT_CNTw*M-1:0] grant_cnt_o,
  output logic [STAT_CNTw-1:0]   timeout_cnt_o
`endif
);

  localparam bit WD_EN = (TIMEOUT > 0);
  localparam logic [TOw-1:0] TO_LAST = TOw'((TIMEOUT > 0) ? TIMEOUT - 1 : 0);

  state_t         state_q, state_n;
  logic [M-1:0]   grant_q, grant_n, grant;
  logic [M-1:0]   err_q, err_n;
  logic [Mw-1:0]  ptr_q, ptr_n;
  logic [TOw-1:0] cnt_q, cnt_n;
  logic           evt_q, evt_n;
  logic [M-1:0]   pick_req, win, new_grant;
  logic           win_valid, hold, resp, take;

  generate
    if (M == 1) begin : g_single
      assign grant = reset ? m_cyc_i_all : '0;
    end else begin : g_multi
      assign grant = grant_q;
    end
  endgenerate

  assign resp     = any_s_ack_i | any_s_err_i | any_s_rty_i;
  assign hold     = |(grant & m_cyc_i_all);
  assign pick_req = m_cyc_i_all & ~grant;

  rr_pick #(.N(M), .W(Mw)) u_rr_pick (
    .req    (pick_req),
    .ptr    (ptr_q),
    .winner (win),
    .valid  (win_valid)
  );

  always_comb begin
    state_n   = state_q;
    grant_n   = grant_q;
    ptr_n     = ptr_q;
    cnt_n     = '0;
    err_n     = '0;
    evt_n     = 1'b0;
    take      = 1'b0;
    new_grant = '0;
    case (state_q)
      IDLE: begin
        // Only reachable with a single master, whose grant follows cyc directly.
        if (hold) begin
          state_n   = GRANT;
          new_grant = grant;
        end else if (win_valid) begin
          take = 1'b1;
        end
      end
      GRANT, ABORT: begin
        if (!hold) begin
          if (win_valid) begin
            take = 1'b1;
          end else begin
            grant_n = '0;
            state_n = IDLE;
          end
        end else if (state_q == GRANT && WD_EN && |(grant & m_stb_i_all) && !resp) begin
          if (cnt_q == TO_LAST) begin
            state_n = ABORT;
            err_n   = grant;
            evt_n   = 1'b1;
          end else begin
            cnt_n = cnt_q + 1'b1;
          end
        end
      end
      default: begin
        state_n = IDLE;
        grant_n = '0;
      end
    endcase
    if (take) begin
      grant_n   = win;
      state_n   = GRANT;
      new_grant = win;
      for (int i = 0; i < M; i++) begin
        if (win[i]) ptr_n = (i == M - 1) ? '0 : Mw'(i + 1);
      end
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= IDLE;
      grant_q <= '0;
      ptr_q   <= '0;
      cnt_q   <= '0;
      err_q   <= '0;
      evt_q   <= 1'b0;
    end else begin
      state_q <= state_n;
      grant_q <= grant_n;
      ptr_q   <= ptr_n;
      cnt_q   <= cnt_n;
      err_q   <= err_n;
      evt_q   <= evt_n;
    end
  end

  one_hot_to_bin #(.N(M), .W(Mw)) u_one_hot_to_bin (
    .onehot (grant),
    .bin    (m_grant_bin_o)
  );

  assign m_grant_onehot_o = grant;
  assign m_timeout_err_o  = WD_EN ? err_q : '0;
  assign timeout_evt_o    = WD_EN ? evt_q : 1'b0;
  assign bus_busy_o       = (state_q != IDLE);

`ifdef WB_SCHED_STATS_EN
  logic [STAT_CNTw-1:0] gcnt_q [M];
  logic [STAT_CNTw-1:0] tcnt_q;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      for (int i = 0; i < M; i++) gcnt_q[i] <= '0;
      tcnt_q <= '0;
    end else begin
      for (int i = 0; i < M; i++) begin
        if (new_grant[i] && gcnt_q[i] != '1) gcnt_q[i] <= gcnt_q[i] + 1'b1;
      end
      if (WD_EN && evt_n && tcnt_q != '1) tcnt_q <= tcnt_q + 1'b1;
    end
  end

  generate
    for (genvar g = 0; g < M; g++) begin : g_stat
      assign grant_cnt_o[g*STAT_CNTw +: STAT_CNTw] = gcnt_q[g];
    end
  endgenerate
  assign timeout_cnt_o = tcnt_q;
`endif

endmodule

// File: tb/tb_wb_bus_scheduler.sv
// tb/tb_wb_bus_scheduler.sv - table-driven scoreboard bench for wb_bus_scheduler (M=4, TIMEOUT=8)
module tb_wb_bus_scheduler;

  logic       clk = 1'b0;
  logic       reset = 1'b0;
  logic [3:0] cyc = '0, stb = '0;
  logic       ack = 1'b0, serr = 1'b0, rty = 1'b0;
  logic [3:0] grant, terr;
  logic [1:0] bin;
  logic       busy, evt;
`ifdef WB_SCHED_STATS_EN
  logic [63:0] grant_cnt;
  logic [15:0] timeout_cnt;
`endif

  wb_bus_scheduler #(.M(4), .TIMEOUT(8)) dut (
    .clk              (clk),
    .reset            (reset),
    .m_cyc_i_all      (cyc),
    .m_stb_i_all      (stb),
    .any_s_ack_i      (ack),
    .any_s_err_i      (serr),
    .any_s_rty_i      (rty),
    .m_grant_onehot_o (grant),
    .m_grant_bin_o    (bin),
    .m_timeout_err_o  (terr),
    .bus_busy_o       (busy),
    .timeout_evt_o    (evt)
`ifdef WB_SCHED_STATS_EN
    ,
    .grant_cnt_o      (grant_cnt),
    .timeout_cnt_o    (timeout_cnt)
`endif
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [3:0] cyc;
    logic [3:0] stb;
    logic       ack;
    logic [3:0] grant;
    logic       busy;
    logic [3:0] err;
    logic       evt;
  } vec_t;

  vec_t        tbl[$];
  logic [11:0] sb[$];
  int          errors = 0;
  int          checks = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  function automatic logic [1:0] bin_of(input logic [3:0] g);
    case (g)
      4'b0010: return 2'd1;
      4'b0100: return 2'd2;
      4'b1000: return 2'd3;
      default: return 2'd0;
    endcase
  endfunction

  task automatic add(input logic [3:0] c, input logic [3:0] s, input logic a,
                     input logic [3:0] g, input logic b, input logic [3:0] e, input logic ev);
    vec_t v;
    v.cyc = c; v.stb = s; v.ack = a; v.grant = g; v.busy = b; v.err = e; v.evt = ev;
    tbl.push_back(v);
  endtask

  task automatic run_table(input string tag);
    logic [11:0] exp;
    foreach (tbl[i]) begin
      cyc = tbl[i].cyc;
      stb = tbl[i].stb;
      ack = tbl[i].ack;
      sb.push_back({tbl[i].grant, bin_of(tbl[i].grant), tbl[i].busy, tbl[i].err, tbl[i].evt});
      @(posedge clk);
      #1;
      exp = sb.pop_front();
      check($sformatf("%s[%0d] {grant,bin,busy,err,evt}", tag, i), {grant, bin, busy, terr, evt}, exp);
      checks++;
      if (!$onehot0(grant)) begin
        errors++;
        $display("FAIL %s[%0d] onehot: got grant %b required one-hot or zero", tag, i, grant);
      end
    end
    tbl.delete();
  endtask

  task automatic do_reset();
    reset = 1'b0;
    cyc = '0; stb = '0; ack = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    check("reset grant", grant, 0);
    check("reset busy", busy, 0);
    check("reset err", terr, 0);
    check("reset evt", evt, 0);
    reset = 1'b1;
  endtask

  initial begin
    #200000;
    $display("FAIL global time limit reached");
    $fatal(1);
  end

  initial begin
    do_reset();
    add(4'b0101, 0, 0, 4'b0001, 1, 0, 0);
    add(4'b0101, 0, 0, 4'b0001, 1, 0, 0);
    add(4'b0100, 0, 0, 4'b0100, 1, 0, 0);
    add(4'b0100, 0, 0, 4'b0100, 1, 0, 0);
    add(4'b0000, 0, 0, 4'b0000, 0, 0, 0);
    run_table("handoff");

    do_reset();
    add(4'b1111, 0, 0, 4'b0001, 1, 0, 0);
    for (int k = 0; k < 4; k++) begin
      add(4'b1111, 0, 0, 4'(1 << k), 1, 0, 0);
      add(4'b1111, 0, 0, 4'(1 << k), 1, 0, 0);
      add(4'b1111 & ~4'(1 << k), 0, 0, 4'(1 << ((k + 1) % 4)), 1, 0, 0);
    end
    add(4'b0000, 0, 0, 4'b0000, 0, 0, 0);
    run_table("rr");

    do_reset();
    add(4'b0100, 4'b0100, 0, 4'b0100, 1, 0, 0);
    repeat (7) add(4'b0100, 4'b0100, 0, 4'b0100, 1, 0, 0);
    add(4'b0100, 4'b0100, 0, 4'b0100, 1, 4'b0100, 1);
    repeat (2) add(4'b0100, 4'b0100, 0, 4'b0100, 1, 0, 0);
    add(4'b0000, 0, 0, 4'b0000, 0, 0, 0);
    run_table("wdog");

    do_reset();
    add(4'b0100, 4'b0100, 0, 4'b0100, 1, 0, 0);
    repeat (7) add(4'b0100, 4'b0100, 0, 4'b0100, 1, 0, 0);
    add(4'b0100, 4'b0100, 1, 4'b0100, 1, 0, 0);
    repeat (7) add(4'b0100, 4'b0100, 0, 4'b0100, 1, 0, 0);
    add(4'b0100, 4'b0100, 0, 4'b0100, 1, 4'b0100, 1);
    add(4'b0000, 0, 0, 4'b0000, 0, 0, 0);
    run_table("ackrace");

    do_reset();
    add(4'b0010, 4'b0010, 0, 4'b0010, 1, 0, 0);
    add(4'b0010, 4'b0010, 0, 4'b0010, 1, 0, 0);
    run_table("preasync");
    #2;
    reset = 1'b0;
    #1;
    check("async grant", grant, 0);
    check("async busy", busy, 0);
    check("async err", {terr, evt}, 0);
    #1;
    reset = 1'b1;
    add(4'b1001, 0, 0, 4'b0001, 1, 0, 0);
    add(4'b1000, 0, 0, 4'b1000, 1, 0, 0);
    add(4'b0000, 0, 0, 4'b0000, 0, 0, 0);
    run_table("postasync");

`ifdef WB_SCHED_STATS_EN
    do_reset();
    repeat (5) begin
      add(4'b0010, 0, 0, 4'b0010, 1, 0, 0);
      add(4'b0000, 0, 0, 4'b0000, 0, 0, 0);
    end
    repeat (2) begin
      add(4'b0100, 4'b0100, 0, 4'b0100, 1, 0, 0);
      repeat (7) add(4'b0100, 4'b0100, 0, 4'b0100, 1, 0, 0);
      add(4'b0100, 4'b0100, 0, 4'b0100, 1, 4'b0100, 1);
      add(4'b0000, 0, 0, 4'b0000, 0, 0, 0);
    end
    run_table("stats");
    check("stats grant_cnt m1", grant_cnt[31:16], 5);
    check("stats grant_cnt m2", grant_cnt[47:32], 2);
    check("stats timeout_cnt", timeout_cnt, 2);
`endif

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/wb_bus_scheduler.md
Name: wb_bus_scheduler

Overview:
Master-side scheduler for the shared wishbone bus: round-robin arbitration of up to M masters with a registered one-hot grant.
- Adds a bus watchdog that terminates hung transfers with an injected error.
- Drives the bus grant select and per-master error injection, and replaces the plain bus arbiter when bus hang protection is required.
- Sits between master cyc/stb lines and the bus multiplexers; slave ack/err/rty are already OR-reduced.

Parameters:
- M, 4, number of masters (>=1).
- TIMEOUT, 1024, cycles of stb&cyc without ack/err/rty before abort; 0 disables the watchdog.
- TOw, log2(TIMEOUT+1), watchdog counter width (localparam).
- Mw, (M>1)?log2(M):1, binary grant width (localparam).

Ports:
- clk  in  1  bus clock.
- reset  in  1  asynchronous, active-low reset.
- m_cyc_i_all  in  M  master cycle requests.
- m_stb_i_all  in  M  master strobes.
- any_s_ack_i  in  1  OR of slave acks.
- any_s_err_i  in  1  OR of slave errs.
- any_s_rty_i  in  1  OR of slave retries.
- m_grant_onehot_o  out  M  registered one-hot grant.
- m_grant_bin_o  out  Mw  binary form of the grant.
- m_timeout_err_o  out  M  one-cycle error pulse to the granted master on abort.
- bus_busy_o  out  1  state != IDLE.
- timeout_evt_o  out  1  one-cycle pulse per abort.

Behaviour:
- Reset (reset=0, async): state=IDLE; grant=0; rr pointer=0 (master 0 has highest priority); watchdog=0; all outputs 0.
- States: IDLE, GRANT, ABORT.
- IDLE, any m_cyc high:
  - Select the first requester at or after rr pointer, cyclically.
  - Next cycle: grant registered, state=GRANT, rr pointer = winner+1 mod M.
  - Request-to-grant latency is 1 cycle.
- GRANT:
  - Grant held while the granted master's cyc=1; other requests are ignored.
  - Granted cyc drops with other requests pending: next cycle grants the next requester directly (no IDLE bubble).
  - Granted cyc drops with no other requests: next cycle grant=0, IDLE.
- Watchdog, in GRANT:
  - Counts up while granted stb&cyc=1 and ack/err/rty=0.
  - Cleared on any ack/err/rty, on stb low, and on grant change.
  - Reaching TIMEOUT: m_timeout_err_o[granted]=1 and timeout_evt_o=1 for exactly one cycle; state=ABORT.
  - Slave ack in the same cycle the count hits TIMEOUT: ack wins, no abort, counter cleared.
- ABORT:
  - Grant held and no further error pulses.
  - Exit when granted cyc=0, using the same handoff rule as GRANT.
- M=1: grant=m_cyc_i_all combinationally; watchdog still active.
- Grant is never 0 while state=GRANT or ABORT, and is always one-hot or 0.
- Reset asserted mid-transfer: immediate grant=0, no error pulse.
- rr pointer wrap-around: M-1 -> 0.
- TIMEOUT=0: state never enters ABORT; m_timeout_err_o and timeout_evt_o tied 0.

Optional Feature:
- Macro: WB_SCHED_STATS_EN.
- Defined:
  - Adds output grant_cnt_o [16*M]: per-master saturating (0xFFFF) grant counters, incremented on each new grant.
  - Adds output timeout_cnt_o [16]: saturating abort count.
  - All counters reset to 0.
- Undefined: these ports and counters are absent; all other behaviour is identical.

Decomposition:
- Shared package wb_sched_pkg:
  - State encoding IDLE=2'd0, GRANT=2'd1, ABORT=2'd2.
  - log2 function.
  - Counter width STAT_CNTw=16.
- Sub-module rr_pick: combinational rotate/priority/un-rotate. Inputs: request vector and pointer. Outputs: one-hot winner and any-valid flag. Instantiated once.
- One-hot to binary conversion reuses the existing one_hot_to_bin.

Test Plan:
- Reset, then m_cyc=4'b0101 → grant=4'b0001 one cycle later. Master 0 drops cyc → grant=4'b0100 next cycle, no IDLE cycle between.
- All four masters request continuously, each holding cyc 3 cycles → grant order 0,1,2,3,0; never two bits set.
- TIMEOUT=8, master 2 holds stb&cyc with no ack → m_timeout_err_o=4'b0100 and timeout_evt_o=1 for exactly one cycle, 8 cycles after stb. Grant held until cyc drops.
- TIMEOUT=8, ack arrives in cycle 8 → no error pulse, and the counter restarts on the next beat.
- Async reset pulse low mid-GRANT → grant=0 immediately, before the clock edge. After release, request from master 3 → grant=4'b1000 (pointer back at 0).
- WB_SCHED_STATS_EN defined, 5 grants to master 1 and 2 aborts → grant_cnt_o[31:16]=5, timeout_cnt_o=2.
